// File: rtl/param_register_file.sv
// -----------------------------------------------------------------------------
// param_register_file
//
// Purpose:
//   Parametrised processor register file. It has DEPTH registers of DATA_W
//   bits, two combinational read ports and one synchronous write port. It also
//   keeps a per-register "pending" scoreboard so the issue stage can stall on
//   operands that are still waiting for a write-back.
//   Optional features:
//     BYPASS   - a same-cycle write is forwarded to any read port that
//                addresses the register being written.
//     ZERO_REG - register 0 is hardwired to zero and can never be pending.
//
// Ports:
//   clk         in   1       rising-edge clock for all state
//   rst_n       in   1       asynchronous active-low clear of data and pending
//   read_adr_a  in   ADDR_W  read port A address
//   read_adr_b  in   ADDR_W  read port B address
//   reg_a       out  DATA_W  read port A data (combinational)
//   reg_b       out  DATA_W  read port B data (combinational)
//   pend_a      out  1       register at read_adr_a awaits write-back
//   pend_b      out  1       register at read_adr_b awaits write-back
//   write_en    in   1       write strobe
//   write_adr   in   ADDR_W  write address
//   write_data  in   DATA_W  write data
//   rsv_en      in   1       reserve strobe (marks a register pending)
//   rsv_adr     in   ADDR_W  register to reserve
//   pend_vec    out  DEPTH   all pending bits, bit i = register i
// -----------------------------------------------------------------------------
module param_register_file #(
  parameter int DATA_W   = 48,
  parameter int DEPTH    = 4,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [$clog2(DEPTH)-1:0]   read_adr_a,
  input  logic [$clog2(DEPTH)-1:0]   read_adr_b,
  output logic [DATA_W-1:0]          reg_a,
  output logic [DATA_W-1:0]          reg_b,
  output logic                       pend_a,
  output logic                       pend_b,
  input  logic                       write_en,
  input  logic [$clog2(DEPTH)-1:0]   write_adr,
  input  logic [DATA_W-1:0]          write_data,
  input  logic                       rsv_en,
  input  logic [$clog2(DEPTH)-1:0]   rsv_adr,
  output logic [DEPTH-1:0]           pend_vec
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int NPORTS = 2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] reg_q [DEPTH];
  logic [DATA_W-1:0] reg_d [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;

  // Per-register decoded strobes
  logic [DEPTH-1:0]  wr_hit;
  logic [DEPTH-1:0]  rsv_hit;

  // ---------------------------------------------------------------------------
  // Next-state logic, one slice per register
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
        // Hardwired zero register: writes and reserves are dropped, so it
        // keeps its reset value forever and is never marked pending.
        assign wr_hit[gi]  = 1'b0;
        assign rsv_hit[gi] = 1'b0;
      end else begin : g_normal
        assign wr_hit[gi]  = write_en && (write_adr == ADDR_W'(gi));
        assign rsv_hit[gi] = rsv_en   && (rsv_adr   == ADDR_W'(gi));
      end

      assign reg_d[gi]  = wr_hit[gi] ? write_data : reg_q[gi];
      // A reserve wins over a same-cycle write-back: the reservation belongs
      // to a newer producer than the one whose result is being written.
      assign pend_d[gi] = rsv_hit[gi] | (pend_q[gi] & ~wr_hit[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i] <= '0;
      end
      pend_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i] <= reg_d[i];
      end
      pend_q <= pend_d;
    end
  end

  assign pend_vec = pend_q;

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] rd_adr  [NPORTS];
  logic [DATA_W-1:0] rd_data [NPORTS];
  logic [NPORTS-1:0] rd_pend;
  logic [NPORTS-1:0] byp_hit;
  logic [NPORTS-1:0] zero_hit;

  assign rd_adr[0] = read_adr_a;
  assign rd_adr[1] = read_adr_b;

  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_port
      // Forwarding only applies while a write is actually in flight.
      assign byp_hit[gi]  = (BYPASS != 0) && write_en && (rd_adr[gi] == write_adr);
      assign zero_hit[gi] = (ZERO_REG != 0) && (rd_adr[gi] == '0);

      // The zero register masks everything, including a bypass match.
      assign rd_data[gi] = zero_hit[gi] ? '0 :
                           byp_hit[gi]  ? write_data :
                                          reg_q[rd_adr[gi]];

      // On a bypass hit the write clears the pending bit, unless a reserve
      // to the same register re-arms it in the same cycle.
      assign rd_pend[gi] = !zero_hit[gi] &&
                           (byp_hit[gi] ? (rsv_en && (rsv_adr == rd_adr[gi]))
                                        : pend_q[rd_adr[gi]]);
    end
  endgenerate

  assign reg_a  = rd_data[0];
  assign reg_b  = rd_data[1];
  assign pend_a = rd_pend[0];
  assign pend_b = rd_pend[1];

endmodule

// File: tb/tb_param_register_file.sv
// -----------------------------------------------------------------------------
// tb_param_register_file
//
// Three instances of param_register_file:
//   dut0: DATA_W=48, DEPTH=4, BYPASS=1, ZERO_REG=0
//   dut1: DATA_W=48, DEPTH=4, BYPASS=0, ZERO_REG=0
//   dut2: DATA_W=32, DEPTH=8, BYPASS=1, ZERO_REG=1
// A directed reset sequence and a vector table cover the corner cases, then
// random traffic is compared against an array-based reference model.
// -----------------------------------------------------------------------------
module tb_param_register_file;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Stimulus, indexed by DUT number; narrower DUTs use the low bits.
  logic        we   [3];
  logic        rsv  [3];
  logic [2:0]  wadr [3];
  logic [2:0]  radr [3];
  logic [2:0]  ra   [3];
  logic [2:0]  rb   [3];
  logic [47:0] wd   [3];

  // Per-instance outputs
  logic [47:0] u0_ra, u0_rb, u1_ra, u1_rb;
  logic [31:0] u2_ra, u2_rb;
  logic        u0_pa, u0_pb, u1_pa, u1_pb, u2_pa, u2_pb;
  logic [3:0]  u0_pv, u1_pv;
  logic [7:0]  u2_pv;

  // Observed outputs, widened for uniform checking
  logic [47:0] o_ra [3];
  logic [47:0] o_rb [3];
  logic        o_pa [3];
  logic        o_pb [3];
  logic [7:0]  o_pv [3];

  assign o_ra[0] = u0_ra;
  assign o_rb[0] = u0_rb;
  assign o_pa[0] = u0_pa;
  assign o_pb[0] = u0_pb;
  assign o_pv[0] = {4'b0, u0_pv};
  assign o_ra[1] = u1_ra;
  assign o_rb[1] = u1_rb;
  assign o_pa[1] = u1_pa;
  assign o_pb[1] = u1_pb;
  assign o_pv[1] = {4'b0, u1_pv};
  assign o_ra[2] = {16'b0, u2_ra};
  assign o_rb[2] = {16'b0, u2_rb};
  assign o_pa[2] = u2_pa;
  assign o_pb[2] = u2_pb;
  assign o_pv[2] = u2_pv;

  param_register_file #(.DATA_W(48), .DEPTH(4), .BYPASS(1), .ZERO_REG(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .read_adr_a(ra[0][1:0]), .read_adr_b(rb[0][1:0]),
    .reg_a(u0_ra), .reg_b(u0_rb), .pend_a(u0_pa), .pend_b(u0_pb),
    .write_en(we[0]), .write_adr(wadr[0][1:0]), .write_data(wd[0]),
    .rsv_en(rsv[0]), .rsv_adr(radr[0][1:0]), .pend_vec(u0_pv)
  );

  param_register_file #(.DATA_W(48), .DEPTH(4), .BYPASS(0), .ZERO_REG(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .read_adr_a(ra[1][1:0]), .read_adr_b(rb[1][1:0]),
    .reg_a(u1_ra), .reg_b(u1_rb), .pend_a(u1_pa), .pend_b(u1_pb),
    .write_en(we[1]), .write_adr(wadr[1][1:0]), .write_data(wd[1]),
    .rsv_en(rsv[1]), .rsv_adr(radr[1][1:0]), .pend_vec(u1_pv)
  );

  param_register_file #(.DATA_W(32), .DEPTH(8), .BYPASS(1), .ZERO_REG(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .read_adr_a(ra[2]), .read_adr_b(rb[2]),
    .reg_a(u2_ra), .reg_b(u2_rb), .pend_a(u2_pa), .pend_b(u2_pb),
    .write_en(we[2]), .write_adr(wadr[2]), .write_data(wd[2][31:0]),
    .rsv_en(rsv[2]), .rsv_adr(radr[2]), .pend_vec(u2_pv)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping and reference model
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;

  logic [47:0] m_reg  [3][8];
  bit          m_pend [3][8];

  function automatic int dep(input int d);
    return (d == 2) ? 8 : 4;
  endfunction

  function automatic bit byp(input int d);
    return d != 1;
  endfunction

  function automatic bit zr(input int d);
    return d == 2;
  endfunction

  function automatic logic [47:0] dmask(input int d);
    return (d == 2) ? 48'h0000_FFFF_FFFF : 48'hFFFF_FFFF_FFFF;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 8; i++) begin
        m_reg[d][i]  = '0;
        m_pend[d][i] = 1'b0;
      end
  endtask

  // What a read port must show right now, from the stored model state and
  // the inputs currently applied.
  task automatic model_read(input int d, input logic [2:0] adr,
                            output logic [47:0] data, output bit pend);
    if (zr(d) && adr == 0) begin
      data = '0;
      pend = 1'b0;
    end else if (byp(d) && we[d] && wadr[d] == adr) begin
      data = wd[d] & dmask(d);
      pend = rsv[d] && (radr[d] == adr);
    end else begin
      data = m_reg[d][adr];
      pend = m_pend[d][adr];
    end
  endtask

  function automatic logic [7:0] model_pvec(input int d);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < dep(d); i++) v[i] = m_pend[d][i];
    return v;
  endfunction

  // Effect of one rising edge with the current inputs.
  task automatic model_edge(input int d);
    if (we[d] && !(zr(d) && wadr[d] == 0)) begin
      m_reg[d][wadr[d]]  = wd[d] & dmask(d);
      m_pend[d][wadr[d]] = 1'b0;
    end
    if (rsv[d] && !(zr(d) && radr[d] == 0))
      m_pend[d][radr[d]] = 1'b1;
  endtask

  task automatic chk(input string name, input int d,
                     input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d t=%0t: got %0h, expected %0h", name, d, $time, act, exp);
    end
  endtask

  task automatic check_all(input int d, input logic [47:0] ea, input logic [47:0] eb,
                           input bit epa, input bit epb, input logic [7:0] epv);
    chk("reg_a",    d, 64'(o_ra[d]), 64'(ea));
    chk("reg_b",    d, 64'(o_rb[d]), 64'(eb));
    chk("pend_a",   d, 64'(o_pa[d]), 64'(epa));
    chk("pend_b",   d, 64'(o_pb[d]), 64'(epb));
    chk("pend_vec", d, 64'(o_pv[d]), 64'(epv));
  endtask

  task automatic idle_all();
    for (int d = 0; d < 3; d++) begin
      we[d] = 0; rsv[d] = 0; wadr[d] = 0; radr[d] = 0;
      ra[d] = 0; rb[d] = 0; wd[d] = 0;
    end
  endtask

  task automatic drive(input int d, input bit w, input logic [2:0] wa, input logic [47:0] wdat,
                       input bit r, input logic [2:0] rsa, input logic [2:0] a, input logic [2:0] b);
    we[d] = w; wadr[d] = wa; wd[d] = wdat;
    rsv[d] = r; radr[d] = rsa; ra[d] = a; rb[d] = b;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    int          d;
    bit          w;
    logic [2:0]  wa;
    logic [47:0] wdat;
    bit          r;
    logic [2:0]  rsa;
    logic [2:0]  a;
    logic [2:0]  b;
    logic [47:0] ea;
    logic [47:0] eb;
    bit          epa;
    bit          epb;
    logic [7:0]  epv;
  } vec_t;

  vec_t tab [19];

  initial begin
    logic [47:0] ea, eb;
    bit          epa, epb;

    // No bypass: old value in the write cycle, new value one cycle later.
    tab[0]  = '{1, 1, 2, 48'h1234_5678_9ABC, 0, 0, 2, 2, 48'h0, 48'h0, 0, 0, 8'h00};
    tab[1]  = '{1, 0, 0, 48'h0, 0, 0, 2, 2, 48'h1234_5678_9ABC, 48'h1234_5678_9ABC, 0, 0, 8'h00};
    // Bypass on both ports in the write cycle.
    tab[2]  = '{0, 1, 3, 48'hDEAD_BEEF_0001, 0, 0, 3, 3, 48'hDEAD_BEEF_0001, 48'hDEAD_BEEF_0001, 0, 0, 8'h00};
    // Scoreboard: reserve 1, hold, write 1 two cycles later.
    tab[3]  = '{0, 0, 0, 48'h0, 1, 1, 1, 3, 48'h0, 48'hDEAD_BEEF_0001, 0, 0, 8'h00};
    tab[4]  = '{0, 0, 0, 48'h0, 0, 0, 1, 3, 48'h0, 48'hDEAD_BEEF_0001, 1, 0, 8'h02};
    tab[5]  = '{0, 0, 0, 48'h0, 0, 0, 1, 3, 48'h0, 48'hDEAD_BEEF_0001, 1, 0, 8'h02};
    tab[6]  = '{0, 1, 1, 48'h5, 0, 0, 1, 3, 48'h5, 48'hDEAD_BEEF_0001, 0, 0, 8'h02};
    tab[7]  = '{0, 0, 0, 48'h0, 0, 0, 1, 3, 48'h5, 48'hDEAD_BEEF_0001, 0, 0, 8'h00};
    // Same-cycle write + reserve to a pending register keeps it pending.
    tab[8]  = '{0, 0, 0, 48'h0, 1, 2, 2, 2, 48'h0, 48'h0, 0, 0, 8'h00};
    tab[9]  = '{0, 1, 2, 48'hAAAA, 1, 2, 2, 1, 48'hAAAA, 48'h5, 1, 0, 8'h04};
    tab[10] = '{0, 0, 0, 48'h0, 0, 0, 2, 1, 48'hAAAA, 48'h5, 1, 0, 8'h04};
    // Write 2 while reserving 0: both take effect independently.
    tab[11] = '{0, 1, 2, 48'hBBBB, 1, 0, 2, 0, 48'hBBBB, 48'h0, 0, 0, 8'h04};
    tab[12] = '{0, 0, 0, 48'h0, 0, 0, 2, 0, 48'hBBBB, 48'h0, 0, 1, 8'h01};
    // Zero register: write/reserve to 0 dropped, even on a bypass match.
    tab[13] = '{2, 1, 0, 48'hFFFF_FFFF, 1, 0, 0, 0, 48'h0, 48'h0, 0, 0, 8'h00};
    tab[14] = '{2, 0, 0, 48'h0, 0, 0, 0, 0, 48'h0, 48'h0, 0, 0, 8'h00};
    // Top address writes and reads back without aliasing onto register 3.
    tab[15] = '{2, 1, 7, 48'h1234_5678, 0, 0, 7, 3, 48'h1234_5678, 48'h0, 0, 0, 8'h00};
    tab[16] = '{2, 0, 0, 48'h0, 0, 0, 7, 3, 48'h1234_5678, 48'h0, 0, 0, 8'h00};
    tab[17] = '{2, 0, 0, 48'h0, 1, 7, 7, 0, 48'h1234_5678, 48'h0, 0, 0, 8'h00};
    tab[18] = '{2, 0, 0, 48'h0, 0, 0, 7, 0, 48'h1234_5678, 48'h0, 1, 0, 8'h80};

    idle_all();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- Reset sequence on dut0: fill, then clear between edges ----
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(0, 1, 3'(i), 48'h1111_0000_0000 + 48'(i + 1), 1, 3'((i + 1) % 4), 0, 0);
      @(posedge clk);
    end
    @(negedge clk);
    idle_all();
    ra[0] = 1; rb[0] = 2;
    #1;
    chk("prefill_nonzero", 0, 64'(o_ra[0] != 0), 64'(1));
    #1;
    rst_n = 1'b0;
    #1;
    check_all(0, 48'h0, 48'h0, 0, 0, 8'h00);
    $display("[dut0] async reset mid-cycle: reg_a=%0h reg_b=%0h pend_vec=%0h", o_ra[0], o_rb[0], o_pv[0]);
    // Bypass still forwards during reset; reset wins over the edge write.
    drive(0, 1, 3, 48'h7777_7777_7777, 1, 3, 3, 2);
    #1;
    check_all(0, 48'h7777_7777_7777, 48'h0, 1, 0, 8'h00);
    @(posedge clk);
    #1;
    chk("reset_priority_pv", 0, 64'(o_pv[0]), 64'(0));
    @(negedge clk);
    idle_all();
    ra[0] = 3;
    rst_n = 1'b1;
    #1;
    chk("reset_priority_reg", 0, 64'(o_ra[0]), 64'(0));
    $display("[dut0] after reset release: reg_a(3)=%0h pend_vec=%0h", o_ra[0], o_pv[0]);

    // ---- Vector table ----
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      idle_all();
      drive(tab[i].d, tab[i].w, tab[i].wa, tab[i].wdat, tab[i].r, tab[i].rsa, tab[i].a, tab[i].b);
      #1;
      check_all(tab[i].d, tab[i].ea, tab[i].eb, tab[i].epa, tab[i].epb, tab[i].epv);
      $display("[dut%0d] vec %0d: we=%0b wadr=%0d rsv=%0b radr=%0d ra=%0d rb=%0d -> reg_a=%0h reg_b=%0h pa=%0b pb=%0b pv=%0h",
               tab[i].d, i, tab[i].w, tab[i].wa, tab[i].r, tab[i].rsa, tab[i].a, tab[i].b,
               o_ra[tab[i].d], o_rb[tab[i].d], o_pa[tab[i].d], o_pb[tab[i].d], o_pv[tab[i].d]);
      @(posedge clk);
    end

    // ---- Random traffic against the model ----
    @(negedge clk);
    idle_all();
    rst_n = 1'b0;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < 250; c++) begin
        @(negedge clk);
        idle_all();
        if ($urandom_range(0, 39) == 0) begin
          rst_n = 1'b0;
          model_clear();
          #1;
          check_all(d, 48'h0, 48'h0, 0, 0, 8'h00);
          $display("[dut%0d] rnd %0d: reset pulse", d, c);
          @(posedge clk);
          #1;
          rst_n = 1'b1;
        end else begin
          drive(d, 1'($urandom_range(0, 1)), 3'($urandom_range(0, dep(d) - 1)),
                {16'($urandom), 32'($urandom)} & dmask(d),
                1'($urandom_range(0, 9) < 4), 3'($urandom_range(0, dep(d) - 1)),
                3'($urandom_range(0, dep(d) - 1)), 3'($urandom_range(0, dep(d) - 1)));
          #1;
          model_read(d, ra[d], ea, epa);
          model_read(d, rb[d], eb, epb);
          check_all(d, ea, eb, epa, epb, model_pvec(d));
          $display("[dut%0d] rnd %0d: we=%0b wadr=%0d rsv=%0b radr=%0d ra=%0d rb=%0d -> reg_a=%0h reg_b=%0h pv=%0h",
                   d, c, we[d], wadr[d], rsv[d], radr[d], ra[d], rb[d], o_ra[d], o_rb[d], o_pv[d]);
          @(posedge clk);
          model_edge(d);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/param_register_file.md
Name: param_register_file

Overview:
Parametrised successor to the 4x48 processor register file. It provides DEPTH registers of DATA_W bits, two combinational read ports and one synchronous write port. It adds an asynchronous clear, an optional hardwired-zero register 0, optional write-to-read bypass, and a per-register pending scoreboard so the issue stage can stall on registers awaiting a write-back.

Parameters:
DATA_W, 48, register width in bits
DEPTH, 4, number of registers; power of two, >= 2
ADDR_W, $clog2(DEPTH), address width; derived localparam, not overridable
BYPASS, 1, 1 = read ports forward write_data on an address match with write_en; 0 = reads always return stored contents
ZERO_REG, 0, 1 = register 0 always reads 0, ignores writes and is never pending

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
read_adr_a  input  ADDR_W  read port A address
read_adr_b  input  ADDR_W  read port B address
reg_a  output  DATA_W  read port A data
reg_b  output  DATA_W  read port B data
pend_a  output  1  register at read_adr_a awaits write-back
pend_b  output  1  register at read_adr_b awaits write-back
write_en  input  1  write strobe
write_adr  input  ADDR_W  write address
write_data  input  DATA_W  write data
rsv_en  input  1  reserve strobe; marks a register pending when an instruction issues
rsv_adr  input  ADDR_W  register to reserve
pend_vec  output  DEPTH  all pending bits, bit i = register i

Behaviour:
- Reset, while rst_n = 0 (independent of clk):
  - all registers clear to 0 and all pending bits clear to 0
  - reg_a, reg_b = 0; pend_a, pend_b = 0; pend_vec = 0, unless the bypass path is active (below)
  - Reset takes priority over any write or reserve arriving in the same cycle.
- Write: on a clk rise with write_en = 1, reg[write_adr] <= write_data and pend[write_adr] <= 0. The stored value is visible one cycle later through the array.
- Reserve: on a clk rise with rsv_en = 1, pend[rsv_adr] <= 1.
- Write and reserve to the same address in the same cycle: the data is written and the pending bit ends at 1, because the reservation belongs to a newer producer.
- Write and reserve to different addresses: both take effect independently.
- Reads are combinational, with zero-cycle latency from address to data.
- BYPASS = 1 and write_en = 1 and read_adr_x == write_adr:
  - reg_x = write_data
  - pend_x = 1 only if rsv_en = 1 and rsv_adr == read_adr_x; otherwise 0
- Without a bypass hit: reg_x = reg[read_adr_x] and pend_x = pend[read_adr_x].
- BYPASS = 0: a same-cycle write is not visible on a read port until the next cycle.
- Both read ports may address the same register, and both return identical values.
- ZERO_REG = 1:
  - writes to address 0 are dropped
  - reserves to address 0 are dropped
  - reg_x = 0 and pend_x = 0 when read_adr_x = 0, even on a bypass match
  - pend_vec[0] is tied to 0
- Pending bits are sticky until a write to the same address clears them. A second reserve of a register that is already pending leaves it at 1; no count is kept.
- Reset asserted mid-operation clears everything on the next evaluation. The first edge after rst_n rises behaves as a normal cycle.

Test Plan:
- Reset: DEPTH = 4, fill every register with non-zero data, pulse rst_n low between edges -> reg_a = reg_b = 0 and pend_vec = 4'b0000 immediately, before the next edge.
- Write then read, BYPASS = 0: write 48'h123456789ABC to address 2, read_adr_a = 2 in the same cycle -> reg_a = old value; next cycle -> reg_a = 48'h123456789ABC.
- Bypass, BYPASS = 1: write_en = 1, write_adr = 3, write_data = 48'hDEAD_BEEF_0001, read_adr_a = read_adr_b = 3 -> both ports show 48'hDEADBEEF0001 in the same cycle.
- Scoreboard: rsv_en = 1, rsv_adr = 1 -> pend_vec = 4'b0010 and pend_a = 1 on address 1. Write to address 1 two cycles later -> pend_vec = 0 after that edge.
- Same-cycle collision: pend[2] = 1, then write_en and rsv_en both target address 2 -> data is stored and pend[2] stays 1. Repeat with rsv_adr = 0 -> pend_vec = 4'b0001 and pend[2] = 0.
- ZERO_REG = 1, DATA_W = 32, DEPTH = 8: write 32'hFFFFFFFF to address 0 and reserve address 0 -> reg_a = 0 and pend_vec[0] = 0. Address 7 still writes and reads back, confirming a 3-bit address wrap with no aliasing.
